// File: rtl/frame_store_responder_pkg.sv
// Shared definitions for the frame-store responder: frame geometry, default
// sizing and the responder FSM state encoding.
package frame_store_responder_pkg;

    localparam int FRAME_WORDS_PER_ROW = 40;
    // Rows are laid out on a power-of-two stride so a row index maps to upper address bits.
    localparam int FRAME_ROW_STRIDE    = 64;
    localparam int FRAME_ROWS          = 480;
    localparam int FRAME_DEPTH         = FRAME_ROWS * FRAME_ROW_STRIDE;

    localparam int DEFAULT_ADDR_W      = 24;
    localparam int DEFAULT_MEM_AW      = 15;
    localparam int DEFAULT_REFRESH_CYC = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_RD_ACK  = 3'd3,
        ST_WR      = 3'd4,
        ST_REF     = 3'd5
    } state_e;

endpackage

// File: rtl/frame_store_responder_if.sv
// Frame-memory request/acknowledge bus. The master is the game/display
// initiator; the slave is the memory responder.
interface frame_store_responder_if
    import frame_store_responder_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic              read;
    logic [ADDR_W-1:0] readAddress;
    logic              readAcknowledge;
    logic [15:0]       readData;
    logic              write;
    logic [ADDR_W-1:0] writeAddress;
    logic [15:0]       writeData;
    logic              writeAcknowledge;
    logic              refresh;
    logic              busy;
    logic [15:0]       refreshCount;

    modport master (
        output read, readAddress, write, writeAddress, writeData, refresh,
        input  readAcknowledge, readData, writeAcknowledge, busy, refreshCount
    );

    modport slave (
        input  read, readAddress, write, writeAddress, writeData, refresh,
        output readAcknowledge, readData, writeAcknowledge, busy, refreshCount
    );
endinterface

// File: rtl/frame_store_responder_ram.sv
// Single-port block RAM with synchronous, read-first output. Contents are
// deliberately never reset so frame data survives a responder reset.
module frame_store_ram
    import frame_store_responder_pkg::*;
#(
    parameter int AW = DEFAULT_MEM_AW,
    parameter int DW = 16
) (
    input  logic          clkDiv,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clkDiv) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_store_responder.sv
// On-chip stand-in for the DDR frame-memory controller: serves word reads,
// word writes and refresh stalls from a block-RAM store.
module frame_store_responder
    import frame_store_responder_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int MEM_AW      = DEFAULT_MEM_AW,
    parameter int DEPTH       = FRAME_DEPTH,
    parameter int REFRESH_CYC = DEFAULT_REFRESH_CYC
) (
    input  logic                    clkDiv,
    input  logic                    rst,
    frame_store_responder_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_CYC + 1);

    state_e            state_q, state_d;
    logic              refresh_pending_q, refresh_pending_d;
    logic              in_range_q, in_range_d;
    logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic [15:0]       refresh_count_q, refresh_count_d;
    logic [15:0]       read_data_q, read_data_d;

    logic              ref_clear;
    logic              ram_en, ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [15:0]       ram_rdata;
    logic              rd_in_range, wr_in_range;

    // Range checks use the full port address so upper bits never alias into the store.
    assign rd_in_range = (bus.readAddress  < ADDR_W'(DEPTH));
    assign wr_in_range = (bus.writeAddress < ADDR_W'(DEPTH));

    frame_store_ram #(
        .AW (MEM_AW),
        .DW (16)
    ) u_ram (
        .clkDiv  (clkDiv),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (bus.writeData),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clkDiv or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            refresh_pending_q <= 1'b0;
            in_range_q        <= 1'b0;
            ref_cnt_q         <= '0;
            refresh_count_q   <= 16'h0000;
            read_data_q       <= 16'h0000;
        end else begin
            state_q           <= state_d;
            refresh_pending_q <= refresh_pending_d;
            in_range_q        <= in_range_d;
            ref_cnt_q         <= ref_cnt_d;
            refresh_count_q   <= refresh_count_d;
            read_data_q       <= read_data_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        in_range_d      = in_range_q;
        ref_cnt_d       = ref_cnt_q;
        refresh_count_d = refresh_count_q;
        read_data_d     = read_data_q;
        ref_clear       = 1'b0;
        ram_en          = 1'b0;
        ram_we          = 1'b0;
        ram_addr        = bus.readAddress[MEM_AW-1:0];

        case (state_q)
            ST_IDLE: begin
                // Refresh first, then write, so a long read burst cannot starve a write.
                if (refresh_pending_q) begin
                    state_d   = ST_REF;
                    ref_cnt_d = '0;
                end else if (bus.write) begin
                    state_d = ST_WR;
                end else if (bus.read) begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                ram_en     = 1'b1;
                in_range_d = rd_in_range;
                state_d    = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                read_data_d = in_range_q ? ram_rdata : 16'h0000;
                state_d     = ST_RD_ACK;
            end
            ST_RD_ACK: begin
                state_d = ST_IDLE;
            end
            ST_WR: begin
                ram_addr = bus.writeAddress[MEM_AW-1:0];
                ram_en   = wr_in_range;
                ram_we   = wr_in_range;
                state_d  = ST_IDLE;
            end
            ST_REF: begin
                if (ref_cnt_q == CNT_W'(REFRESH_CYC - 1)) begin
                    ref_clear       = 1'b1;
                    refresh_count_d = refresh_count_q + 16'h0001;
                    state_d         = ST_IDLE;
                end else begin
                    ref_cnt_d = ref_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new pulse outranks the clear so a request landing on the last REF cycle survives.
        refresh_pending_d = bus.refresh | (refresh_pending_q & ~ref_clear);
    end

    assign bus.readAcknowledge  = (state_q == ST_RD_ACK);
    assign bus.writeAcknowledge = (state_q == ST_WR);
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.readData         = read_data_q;
    assign bus.refreshCount     = refresh_count_q;
endmodule

// File: tb/tb_frame_store_responder.sv
// Scoreboard bench for frame_store_responder: directed scenarios plus a
// randomized phase, checked against an array model of the word store.
module tb_frame_store_responder;
    localparam int ADDR_W      = 24;
    localparam int DEPTH       = 30720;
    localparam int REFRESH_CYC = 8;
    // Word period is IDLE+ADDR+DATA+ACK; a refresh adds its stall plus one more IDLE.
    localparam int WORD_GAP    = 4;
    localparam int REF_GAP     = WORD_GAP + REFRESH_CYC + 1;

    logic clkDiv = 1'b0;
    logic rst    = 1'b1;
    always #5 clkDiv = ~clkDiv;

    frame_store_responder_if #(.ADDR_W(ADDR_W)) bus();

    frame_store_responder #(
        .ADDR_W      (ADDR_W),
        .MEM_AW      (15),
        .DEPTH       (DEPTH),
        .REFRESH_CYC (REFRESH_CYC)
    ) dut (
        .clkDiv (clkDiv),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        bit          is_write;
        logic [23:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_mem [int];
    int          model_refresh = 0;
    int          rd_ack_times[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [15:0] model_read(input logic [23:0] a);
        if (a >= DEPTH) return 16'h0000;
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return 16'hxxxx;
    endfunction

    task automatic expect_push(input bit w, input logic [23:0] a, input logic [15:0] d);
        exp_t e;
        e.is_write = w;
        e.addr     = a;
        e.data     = d;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per acknowledge and checks protocol rules.
    logic [15:0] last_rd_data = 16'h0000;
    int          last_rd_cyc  = -1;
    logic        prev_wack    = 1'b0;
    always @(negedge clkDiv) begin
        exp_t e;
        cyc++;
        if (rst) begin
            last_rd_data = 16'h0000;
            last_rd_cyc  = -1;
            prev_wack    = 1'b0;
        end else begin
            if (bus.readAcknowledge && bus.writeAcknowledge)
                check("ack_exclusive", 32'd1, 32'd0);
            if (bus.readAcknowledge || bus.writeAcknowledge) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    e = exp_q.pop_front();
                    check("ack_kind", {31'd0, bus.writeAcknowledge}, {31'd0, e.is_write});
                    if (bus.readAcknowledge && !e.is_write) begin
                        check("rd_data", {16'd0, bus.readData}, {16'd0, e.data});
                        $display("ack rd addr=%h data=%h", e.addr, bus.readData);
                    end else begin
                        $display("ack wr addr=%h data=%h", e.addr, e.data);
                    end
                end
            end
            if (bus.readAcknowledge) begin
                if (last_rd_cyc >= 0)
                    check("rd_gap_min", {31'd0, (cyc - last_rd_cyc) >= WORD_GAP}, 32'd1);
                rd_ack_times.push_back(cyc);
                last_rd_cyc  = cyc;
                last_rd_data = bus.readData;
            end else begin
                check("rd_data_hold", {16'd0, bus.readData}, {16'd0, last_rd_data});
            end
            if (bus.writeAcknowledge)
                check("wack_single_cycle", {31'd0, prev_wack}, 32'd0);
            prev_wack = bus.writeAcknowledge;
        end
    end

    task automatic do_write(input logic [23:0] a, input logic [15:0] d);
        int t;
        @(negedge clkDiv);
        bus.write        = 1'b1;
        bus.writeAddress = a;
        bus.writeData    = d;
        expect_push(1'b1, a, d);
        if (a < DEPTH) model_mem[int'(a)] = d;
        for (t = 0; t < 100; t++) begin
            @(negedge clkDiv);
            if (bus.writeAcknowledge) break;
        end
        if (t == 100) fail_now("write_wait");
        bus.write = 1'b0;
    endtask

    // mode 1: one refresh pulse on ack number k; mode 2: two pulses inside word k+1.
    task automatic read_burst(input logic [23:0] start, input int n, input int mode, input int k);
        logic [23:0] a;
        int count;
        int c;
        @(negedge clkDiv);
        a               = start;
        bus.read        = 1'b1;
        bus.readAddress = a;
        expect_push(1'b0, a, model_read(a));
        count = 0;
        c     = 0;
        while (count < n) begin
            @(negedge clkDiv);
            c++;
            bus.refresh = (mode == 2 && count == k && (c == 1 || c == 3));
            if (mode == 2 && count == k && c == 1) model_refresh++;
            if (bus.readAcknowledge) begin
                count++;
                c = 0;
                if (count == n) begin
                    bus.read = 1'b0;
                end else begin
                    a               = a + 24'd1;
                    bus.readAddress = a;
                    expect_push(1'b0, a, model_read(a));
                end
                if (mode == 1 && count == k) begin
                    bus.refresh = 1'b1;
                    model_refresh++;
                end
            end else if (c > 40) begin
                fail_now("read_wait");
                bus.read = 1'b0;
                break;
            end
        end
        @(negedge clkDiv);
        bus.refresh = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clkDiv);
    endtask

    function automatic logic [23:0] pick_start();
        case ($urandom_range(0, 3))
            0:       return 24'($urandom_range(0, 32'h60));
            1:       return 24'($urandom_range(DEPTH - 16, DEPTH + 8));
            2:       return 24'($urandom_range(32'h8000, 32'h8008));
            default: return 24'($urandom_range(32'hFFFFE0, 32'hFFFFF0));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a;
        logic [15:0] d;
        int t;
        bit w_done, r_done;

        bus.read = 0; bus.readAddress = '0; bus.write = 0;
        bus.writeAddress = '0; bus.writeData = '0; bus.refresh = 0;

        // Reset state
        idle(3);
        check("rst_rack",  {31'd0, bus.readAcknowledge},  32'd0);
        check("rst_wack",  {31'd0, bus.writeAcknowledge}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy},             32'd0);
        check("rst_rdata", {16'd0, bus.readData},         32'd0);
        check("rst_rcnt",  {16'd0, bus.refreshCount},     32'd0);
        rst = 1'b0;
        idle(2);

        // 1: single write then read back
        do_write(24'h000010, 16'hA5A5);
        idle(2);
        read_burst(24'h000010, 1, 0, 0);
        idle(3);

        // 2: 40-word burst over a preloaded ramp
        for (int n = 0; n < 40; n++) do_write(24'h40 + 24'(n), 16'(n));
        rd_ack_times.delete();
        read_burst(24'h000040, 40, 0, 0);
        idle(20);
        check("burst_ack_count", rd_ack_times.size(), 32'd40);

        // 3: read and write raised together, same address; write must win
        @(negedge clkDiv);
        bus.write = 1'b1; bus.writeAddress = 24'h30; bus.writeData = 16'h7E57;
        bus.read  = 1'b1; bus.readAddress  = 24'h30;
        model_mem[32'h30] = 16'h7E57;
        expect_push(1'b1, 24'h30, 16'h7E57);
        expect_push(1'b0, 24'h30, model_read(24'h30));
        w_done = 0; r_done = 0;
        for (t = 0; t < 100 && !(w_done && r_done); t++) begin
            @(negedge clkDiv);
            if (bus.writeAcknowledge) begin bus.write = 1'b0; w_done = 1; end
            if (bus.readAcknowledge)  begin bus.read  = 1'b0; r_done = 1; end
        end
        if (!(w_done && r_done)) begin
            fail_now("rw_wait");
            bus.write = 1'b0; bus.read = 1'b0;
        end
        idle(5);

        // 4: refresh mid-burst, then two pulses collapsing into one refresh
        rd_ack_times.delete();
        read_burst(24'h000040, 6, 1, 3);
        idle(5);
        check("ref1_acks", rd_ack_times.size(), 32'd6);
        if (rd_ack_times.size() == 6) begin
            check("ref1_gap_plain", rd_ack_times[1] - rd_ack_times[0], WORD_GAP);
            check("ref1_gap_stall", rd_ack_times[3] - rd_ack_times[2], REF_GAP);
        end
        check("ref1_count", {16'd0, bus.refreshCount}, 32'(model_refresh));
        rd_ack_times.delete();
        read_burst(24'h000040, 6, 2, 2);
        idle(20);
        check("ref2_acks", rd_ack_times.size(), 32'd6);
        if (rd_ack_times.size() == 6) begin
            check("ref2_gap_plain", rd_ack_times[2] - rd_ack_times[1], WORD_GAP);
            check("ref2_gap_stall", rd_ack_times[3] - rd_ack_times[2], REF_GAP);
            check("ref2_gap_after", rd_ack_times[4] - rd_ack_times[3], WORD_GAP);
        end
        check("ref2_count", {16'd0, bus.refreshCount}, 32'(model_refresh));

        // 5: out-of-range writes are acked and dropped; aliases must not hit word 0
        do_write(24'h000000, 16'hBEEF);
        do_write(24'(DEPTH - 1), 16'h0FF1);
        do_write(24'(DEPTH), 16'h1234);
        do_write(24'h008000, 16'h5555);
        do_write(24'h800000, 16'h6666);
        read_burst(24'(DEPTH - 1), 2, 0, 0);
        read_burst(24'h008000, 1, 0, 0);
        read_burst(24'h000000, 1, 0, 0);
        idle(3);

        // 6: reset while a read word is in flight
        do_write(24'h000020, 16'h0C0D);
        @(negedge clkDiv);
        bus.read = 1'b1; bus.readAddress = 24'h20;
        for (t = 0; t < 20; t++) begin
            @(negedge clkDiv);
            if (bus.busy) break;
        end
        if (t == 20) fail_now("busy_wait");
        @(negedge clkDiv);
        rst = 1'b1; bus.read = 1'b0;
        #1;
        check("rst_mid_rack",  {31'd0, bus.readAcknowledge}, 32'd0);
        check("rst_mid_busy",  {31'd0, bus.busy},            32'd0);
        check("rst_mid_rdata", {16'd0, bus.readData},        32'd0);
        check("rst_mid_rcnt",  {16'd0, bus.refreshCount},    32'd0);
        idle(3);
        rst = 1'b0;
        model_refresh = 0;
        idle(2);
        read_burst(24'h000020, 1, 0, 0);
        idle(3);

        // Random phase: known windows preloaded, then mixed traffic
        for (int n = 0; n < 16'h40; n++) if (n != 16'h20 && n != 0 && n != 16'h10 && n != 16'h30)
            do_write(24'(n), 16'($urandom));
        for (int n = DEPTH - 16; n < DEPTH - 1; n++) do_write(24'(n), 16'($urandom));
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clkDiv);
                bus.refresh = 1'b1;
                model_refresh++;
                @(negedge clkDiv);
                bus.refresh = 1'b0;
            end
            a = pick_start();
            if ($urandom_range(0, 1) == 0) begin
                d = 16'($urandom);
                do_write(a, d);
            end else begin
                read_burst(a, $urandom_range(1, 6), 0, 0);
            end
        end
        idle(40);
        check("final_rcnt", {16'd0, bus.refreshCount}, 32'(model_refresh));
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
